// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg -- shared constants and types for the dds_wave_gen block.
//
// Holds the phase/data widths, the midscale (0 V) code of the offset-binary
// DAC, the quarter-wave sine LUT geometry and the waveform selector enum.
// -----------------------------------------------------------------------------
package dds_pkg;

  localparam int PHASE_W   = 32;   // phase accumulator width
  localparam int DATA_W    = 14;   // DAC sample width
  localparam int LUT_DEPTH = 256;  // quarter-wave entries
  localparam int LUT_AW    = 8;    // LUT address width
  localparam int LUT_W     = 13;   // LUT magnitude width

  // Offset-binary midscale: the code that produces 0 V at the DAC.
  localparam logic [DATA_W-1:0] MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    WAVE_SAW  = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SQR  = 2'd2,
    WAVE_SINE = 2'd3
  } wave_e;

endpackage

// File: rtl/dds_wave_gen_if.sv
// -----------------------------------------------------------------------------
// dds_wave_gen_if -- configuration and sample bus of the DDS wave generator.
//
// Signals:
//   en          : advance the phase and produce samples
//   freq_word   : phase increment per clock (captured on cfg_load)
//   wave_sel    : 0 saw, 1 triangle, 2 square, 3 sine (captured on cfg_load)
//   amp_shift   : attenuation as a right shift about midscale (captured on cfg_load)
//   cfg_load    : one-cycle pulse copying the three config inputs into a shadow
//   dac_data    : offset-binary sample for the DAC
//   dac_valid   : dac_data carries a new sample this cycle
//   phase_wrap  : one-cycle pulse on accumulator carry-out
//   cfg_pending : shadow config is waiting to be applied
//
// Handshake: there is no back-pressure. dac_valid qualifies dac_data in the
// cycle it is high and the consumer must take the sample then; cfg_load is a
// fire-and-forget strobe that is always accepted, its progress being visible
// on cfg_pending.
// -----------------------------------------------------------------------------
interface dds_wave_gen_if #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 14
);

  logic               en;
  logic [PHASE_W-1:0] freq_word;
  logic [1:0]         wave_sel;
  logic [2:0]         amp_shift;
  logic               cfg_load;
  logic [DATA_W-1:0]  dac_data;
  logic               dac_valid;
  logic               phase_wrap;
  logic               cfg_pending;

  modport master (
    output en, freq_word, wave_sel, amp_shift, cfg_load,
    input  dac_data, dac_valid, phase_wrap, cfg_pending
  );

  modport slave (
    input  en, freq_word, wave_sel, amp_shift, cfg_load,
    output dac_data, dac_valid, phase_wrap, cfg_pending
  );

endinterface

// File: rtl/sine_qlut.sv
// -----------------------------------------------------------------------------
// sine_qlut -- 256 x 13 quarter-wave sine ROM with a registered read.
//
// Entry i holds round(8191 * sin((i + 0.5) * pi / 512)). The half-LSB phase
// offset makes the quarter wave symmetric under address inversion, so the
// other three quadrants are rebuilt by the caller with no extra entries.
//
// Ports:
//   clk_i  : clock
//   addr_i : quarter-wave address
//   mag_o  : magnitude, valid one clock after addr_i
// -----------------------------------------------------------------------------
module sine_qlut
  import dds_pkg::*;
(
  input  logic              clk_i,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [LUT_W-1:0]  mag_o
);

  // Evaluated only at elaboration to build the ROM constants; a Taylor
  // series keeps the contents independent of any tool math library.
  function automatic logic [LUT_W-1:0] sine_entry(input int idx);
    real x;
    real term;
    real sum;
    x    = (real'(idx) + 0.5) * 3.14159265358979323846 / real'(2 * LUT_DEPTH);
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return LUT_W'($rtoi(8191.0 * sum + 0.5));
  endfunction

  logic [LUT_W-1:0] rom [LUT_DEPTH];

  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
    localparam logic [LUT_W-1:0] ENTRY = sine_entry(i);
    assign rom[i] = ENTRY;
  end

  always_ff @(posedge clk_i) begin
    mag_o <= rom[addr_i];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// -----------------------------------------------------------------------------
// dds_wave_gen -- direct digital synthesis waveform generator for a 14-bit
// offset-binary DAC.
//
// A phase accumulator advances by the active frequency word every enabled
// clock. Its value is shaped into sawtooth, triangle, square or sine and
// attenuated about midscale. New configuration is loaded into a shadow and
// applied only on a phase wrap (or immediately while stopped), so waveform
// changes never tear a period.
//
// Pipeline: acc value of cycle n -> stage 1 (raw shape / LUT read) ->
// stage 2 (attenuation) -> dac_data in cycle n+2. dac_valid follows en with
// the same alignment; dac_data holds its last sample while idle.
//
// Ports:
//   clk : DAC sample clock
//   rst : synchronous active-high reset
//   bus : dds_wave_gen_if slave (config in, samples/status out)
// DATA_W must be 14.
// -----------------------------------------------------------------------------
module dds_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 14
) (
  input logic           clk,
  input logic           rst,
  dds_wave_gen_if.slave bus
);

  localparam int TOP = PHASE_W - 1;
  localparam logic [DATA_W-1:0] MID = dds_pkg::MIDSCALE;

  // Accumulator and configuration state
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] fw_act_q, fw_act_d;
  logic [PHASE_W-1:0] fw_sh_q, fw_sh_d;
  dds_pkg::wave_e     wave_act_q, wave_act_d;
  dds_pkg::wave_e     wave_sh_q, wave_sh_d;
  logic [2:0]         amp_act_q, amp_act_d;
  logic [2:0]         amp_sh_q, amp_sh_d;
  logic               pend_q, pend_d;
  logic               wrap_q, wrap_d;
  logic               v0_q;
  logic               carry;
  logic               apply_now;

  // Stage 1
  logic [DATA_W-1:0]  raw_s1;
  logic [DATA_W-1:0]  raw1_q;
  logic               sine1_q;
  logic               neg1_q;
  logic [2:0]         amp1_q;
  logic               v1_q;
  logic [dds_pkg::LUT_AW-1:0] lut_addr;
  logic [dds_pkg::LUT_W-1:0]  lut_mag;

  // Stage 2
  logic [DATA_W-1:0]  raw_s2;
  logic signed [DATA_W:0] diff_s2, shift_s2, sum_s2;
  logic [DATA_W-1:0]  dac_d, dac_q;
  logic               valid_q;

  // Accumulator and shadow-config update
  always_comb begin
    acc_d      = acc_q;
    carry      = 1'b0;
    fw_act_d   = fw_act_q;
    wave_act_d = wave_act_q;
    amp_act_d  = amp_act_q;
    fw_sh_d    = fw_sh_q;
    wave_sh_d  = wave_sh_q;
    amp_sh_d   = amp_sh_q;
    pend_d     = pend_q;

    if (bus.en) begin
      {carry, acc_d} = {1'b0, acc_q} + {1'b0, fw_act_q};
    end
    wrap_d = carry;

    // A pending shadow lands on the wrap edge while running, or on the
    // first clock seen with en low. With fw_act = 0 no wrap ever comes, so
    // only the stopped path can apply.
    apply_now = pend_q & (bus.en ? carry : 1'b1);

    if (bus.cfg_load) begin
      fw_sh_d   = bus.freq_word;
      wave_sh_d = dds_pkg::wave_e'(bus.wave_sel);
      amp_sh_d  = bus.amp_shift;
      if (apply_now) begin
        // A load landing on the apply edge wins over the older shadow.
        fw_act_d   = bus.freq_word;
        wave_act_d = dds_pkg::wave_e'(bus.wave_sel);
        amp_act_d  = bus.amp_shift;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (apply_now) begin
      fw_act_d   = fw_sh_q;
      wave_act_d = wave_sh_q;
      amp_act_d  = amp_sh_q;
      pend_d     = 1'b0;
    end
  end

  // Stage 1 shaping for the non-sine waves
  always_comb begin
    raw_s1 = MID;
    case (wave_act_q)
      dds_pkg::WAVE_SAW: raw_s1 = acc_q[TOP -: DATA_W];
      dds_pkg::WAVE_TRI: raw_s1 = acc_q[TOP] ? ~acc_q[TOP-1 -: DATA_W]
                                             :  acc_q[TOP-1 -: DATA_W];
      dds_pkg::WAVE_SQR: raw_s1 = acc_q[TOP] ? '0 : '1;
      default:           raw_s1 = MID;
    endcase
  end

  // Quadrants 1 and 3 walk the quarter wave backwards.
  assign lut_addr = acc_q[TOP-2 -: dds_pkg::LUT_AW]
                  ^ {dds_pkg::LUT_AW{acc_q[TOP-1]}};

  sine_qlut u_lut (
    .clk_i  (clk),
    .addr_i (lut_addr),
    .mag_o  (lut_mag)
  );

  // Stage 2: rebuild sine sign, then attenuate about midscale. The shifted
  // offset never exceeds the original swing, so no clipping is needed.
  always_comb begin
    raw_s2 = raw1_q;
    if (sine1_q) begin
      raw_s2 = neg1_q ? MID - DATA_W'(lut_mag) : MID + DATA_W'(lut_mag);
    end
    diff_s2  = $signed({1'b0, raw_s2}) - $signed({1'b0, MID});
    shift_s2 = diff_s2 >>> amp1_q;
    sum_s2   = shift_s2 + $signed({1'b0, MID});
    dac_d    = DATA_W'(sum_s2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      fw_act_q   <= '0;
      wave_act_q <= dds_pkg::WAVE_SAW;
      amp_act_q  <= '0;
      fw_sh_q    <= '0;
      wave_sh_q  <= dds_pkg::WAVE_SAW;
      amp_sh_q   <= '0;
      pend_q     <= 1'b0;
      wrap_q     <= 1'b0;
      v0_q       <= 1'b0;
      raw1_q     <= MID;
      sine1_q    <= 1'b0;
      neg1_q     <= 1'b0;
      amp1_q     <= '0;
      v1_q       <= 1'b0;
      dac_q      <= MID;
      valid_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fw_act_q   <= fw_act_d;
      wave_act_q <= wave_act_d;
      amp_act_q  <= amp_act_d;
      fw_sh_q    <= fw_sh_d;
      wave_sh_q  <= wave_sh_d;
      amp_sh_q   <= amp_sh_d;
      pend_q     <= pend_d;
      wrap_q     <= wrap_d;
      // v0 marks that acc_q holds a freshly advanced phase.
      v0_q       <= bus.en;
      raw1_q     <= raw_s1;
      sine1_q    <= (wave_act_q == dds_pkg::WAVE_SINE);
      neg1_q     <= acc_q[TOP];
      amp1_q     <= amp_act_q;
      v1_q       <= v0_q;
      valid_q    <= v1_q;
      if (v1_q) begin
        dac_q <= dac_d;
      end
    end
  end

  assign bus.dac_data    = dac_q;
  assign bus.dac_valid   = valid_q;
  assign bus.phase_wrap  = wrap_q;
  assign bus.cfg_pending = pend_q;

endmodule
